// File: rtl/cpu_pkg.sv
// Shared pipeline-control encodings for the hazard/stall logic:
// Tuse/Tnew codes, mult/div timer width and the per-operand hazard test.
package cpu_pkg;

  localparam int MD_CNT_W = 4;

  // Tuse: cycles until ID consumes an operand; 3 marks an unused operand
  localparam logic [1:0] TUSE_NOW  = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until a producer's result can be forwarded
  localparam logic [1:0] TNEW_NOW = 2'd0;
  localparam logic [1:0] TNEW_1   = 2'd1;
  localparam logic [1:0] TNEW_2   = 2'd2;

  // A consumer stalls only if it needs the value strictly before it exists;
  // equal Tuse/Tnew is covered by forwarding, and $zero never hazards.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] dst,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Busy timer for the multi-cycle mult/div unit: loads on a start pulse,
// counts down to zero, and reports busy for the start cycle plus N cycles.
module md_busy_timer
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_is_div,
  output logic                o_busy,
  output logic [MD_CNT_W-1:0] o_cnt
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] r_md_cnt;

  // A start while already busy simply reloads; overlap is not an error here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (i_start) begin
      r_md_cnt <= i_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  assign o_busy = i_start | (r_md_cnt != '0);
  assign o_cnt  = r_md_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: Tuse/Tnew data-hazard
// detection, mult/div busy interlock, stall/flush outputs and a stall counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_tuse_rs,
  input  logic [1:0]  id_tuse_rt,
  input  logic        id_is_md,
  input  logic [4:0]  ex_wa,
  input  logic [1:0]  ex_tnew,
  input  logic [4:0]  mem_wa,
  input  logic [1:0]  mem_tnew,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        flush_idex,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  logic                w_stall_rs;
  logic                w_stall_rt;
  logic                w_stall_md;
  logic                w_stall;
  logic                w_md_busy;
  logic [MD_CNT_W-1:0] w_md_cnt;
  logic [31:0]         r_stall_count;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .i_start  (ex_md_start),
    .i_is_div (ex_md_is_div),
    .o_busy   (w_md_busy),
    .o_cnt    (w_md_cnt)
  );

  assign w_stall_rs = src_hazard(id_rs, id_tuse_rs, ex_wa, ex_tnew) |
                      src_hazard(id_rs, id_tuse_rs, mem_wa, mem_tnew);
  assign w_stall_rt = src_hazard(id_rt, id_tuse_rt, ex_wa, ex_tnew) |
                      src_hazard(id_rt, id_tuse_rt, mem_wa, mem_tnew);
  assign w_stall_md = id_is_md & w_md_busy;

  // Held low during reset so the pipeline registers see a clean restart
  assign w_stall = ~reset & (w_stall_rs | w_stall_rt | w_stall_md);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_pc    = w_stall;
  assign stall_ifid  = w_stall;
  assign flush_idex  = w_stall;
  assign md_busy     = w_md_busy;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// mult/div/reset/saturation sequences and randomized traffic vs a reference model.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
  logic [1:0]  id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic        id_is_md, ex_md_start, ex_md_is_div;
  logic        stall_pc, stall_ifid, flush_idex, md_busy;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
    .id_is_md(id_is_md), .ex_wa(ex_wa), .ex_tnew(ex_tnew),
    .mem_wa(mem_wa), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_idex(flush_idex),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: absolute cycle index and last cycle the md unit is busy
  int          cyc      = 0;
  int          busy_end = -1;
  logic [31:0] m_count  = 32'd0;

  // Observations from the most recent tick, used by hand-written sequences
  logic        last_stall;
  logic        last_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic needs_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] dst, input logic [1:0] tnew);
    int need_in;
    int ready_in;
    if (src == 0 || tuse == 2'd3 || src != dst) return 1'b0;
    need_in  = int'(tuse);
    ready_in = int'(tnew);
    return need_in < ready_in;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the rising edge
  task automatic tick(input string tag, input bit use_tab, input logic tab_stall);
    logic exp_busy, exp_stall, haz;
    @(negedge clk);
    exp_busy  = ex_md_start | (cyc <= busy_end);
    haz       = needs_stall(id_rs, id_tuse_rs, ex_wa, ex_tnew) |
                needs_stall(id_rs, id_tuse_rs, mem_wa, mem_tnew) |
                needs_stall(id_rt, id_tuse_rt, ex_wa, ex_tnew) |
                needs_stall(id_rt, id_tuse_rt, mem_wa, mem_tnew);
    exp_stall = !reset && (haz || (id_is_md && exp_busy));
    if (use_tab) chk({tag, " stall_pc"}, {31'd0, stall_pc}, {31'd0, tab_stall});
    else         chk({tag, " stall_pc"}, {31'd0, stall_pc}, {31'd0, exp_stall});
    chk({tag, " stall_ifid"}, {31'd0, stall_ifid}, {31'd0, exp_stall});
    chk({tag, " flush_idex"}, {31'd0, flush_idex}, {31'd0, exp_stall});
    chk({tag, " md_busy"}, {31'd0, md_busy}, {31'd0, exp_busy});
    chk({tag, " stall_count"}, stall_count, m_count);
    $display("cyc %0d %s: rs=%0d rt=%0d ex_wa=%0d mem_wa=%0d md=%0b start=%0b stall=%0b busy=%0b cnt=%0h",
             cyc, tag, id_rs, id_rt, ex_wa, mem_wa, id_is_md, ex_md_start,
             stall_pc, md_busy, stall_count);
    last_stall = stall_pc;
    last_busy  = md_busy;
    @(posedge clk);
    if (reset) begin
      busy_end = -1;
      m_count  = 32'd0;
    end else begin
      if (ex_md_start) busy_end = cyc + (ex_md_is_div ? DIV_N : MULT_N);
      if (exp_stall && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3; id_is_md = 0;
    ex_wa = 0; ex_tnew = 0; mem_wa = 0; mem_tnew = 0;
    ex_md_start = 0; ex_md_is_div = 0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] ex_wa;
    logic [1:0] ex_tnew;
    logic [4:0] mem_wa;
    logic [1:0] mem_tnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int stalls, busies;
    vecs.push_back('{"load_use",   5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b1});
    vecs.push_back('{"fwd_ex",     5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 2'd1, 5'd0, 2'd0, 1'b0});
    vecs.push_back('{"rs_zero",    5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0});
    vecs.push_back('{"mem_rt",     5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b1});
    vecs.push_back('{"tuse_none",  5'd8, 5'd8, 2'd3, 2'd3, 5'd8, 2'd2, 5'd8, 2'd1, 1'b0});
    vecs.push_back('{"ex_rt_t0",   5'd1, 5'd9, 2'd2, 2'd0, 5'd9, 2'd1, 5'd0, 2'd0, 1'b1});
    vecs.push_back('{"mem_eq",     5'd7, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0});
    vecs.push_back('{"no_match",   5'd3, 5'd4, 2'd0, 2'd0, 5'd5, 2'd2, 5'd6, 2'd1, 1'b0});
    vecs.push_back('{"tuse2_tnew2",5'd9, 5'd0, 2'd2, 2'd3, 5'd9, 2'd2, 5'd0, 2'd0, 1'b0});

    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;               // flush X state out of the registers
    cyc++;
    tick("reset", 0, 1'b0);
    id_rs = 5'd8; id_tuse_rs = 2'd1; ex_wa = 5'd8; ex_tnew = 2'd2;
    tick("reset_hazard", 1, 1'b0);    // stall masked while reset is high
    idle_inputs();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_tuse_rs = vecs[i].tu_rs; id_tuse_rt = vecs[i].tu_rt;
      ex_wa = vecs[i].ex_wa; ex_tnew = vecs[i].ex_tnew;
      mem_wa = vecs[i].mem_wa; mem_tnew = vecs[i].mem_tnew;
      tick(vecs[i].name, 1, vecs[i].exp_stall);
    end
    idle_inputs();
    tick("idle", 0, 1'b0);

    // Mult window: md instruction in ID stalls from start cycle through t+5
    id_is_md = 1; ex_md_start = 1; ex_md_is_div = 0;
    stalls = 0;
    for (int k = 0; k <= 6; k++) begin
      tick("mult", 0, 1'b0);
      ex_md_start = 0;
      if (k <= 5) stalls += int'(last_stall);
    end
    chk("mult_stall_len", stalls, 6);
    chk("mult_busy_t6", {31'd0, last_busy}, 32'd0);

    // Div window: busy for 11 cycles, a non-md ID instruction never stalls
    idle_inputs();
    ex_md_start = 1; ex_md_is_div = 1;
    busies = 0; stalls = 0;
    for (int k = 0; k <= 11; k++) begin
      tick("div", 0, 1'b0);
      ex_md_start = 0;
      busies += int'(last_busy);
      stalls += int'(last_stall);
    end
    chk("div_busy_len", busies, 11);
    chk("div_nonmd_stalls", stalls, 0);

    // Reset at t+3 of a div drops the pending busy and clears the counter
    idle_inputs();
    id_is_md = 1; ex_md_start = 1; ex_md_is_div = 1;
    tick("rst_div_t0", 0, 1'b0);
    ex_md_start = 0;
    tick("rst_div_t1", 0, 1'b0);
    tick("rst_div_t2", 0, 1'b0);
    reset = 1;
    tick("rst_div_t3", 0, 1'b0);
    reset = 0;
    tick("rst_div_t4", 0, 1'b0);
    chk("rst_busy_t4", {31'd0, last_busy}, 32'd0);
    chk("rst_count_t4", stall_count, 32'd0);
    idle_inputs();

    // Saturation: preload near the top, then stall across the boundary
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_count;
    m_count = 32'hFFFF_FFFE;
    id_rs = 5'd8; id_tuse_rs = 2'd0; ex_wa = 5'd8; ex_tnew = 2'd1;
    for (int k = 0; k < 3; k++) tick("saturate", 0, 1'b0);
    @(negedge clk);
    chk("sat_hold", stall_count, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    cyc++;

    // Randomized traffic against the model
    reset = 1;
    idle_inputs();
    tick("rand_reset", 0, 1'b0);
    reset = 0;
    for (int k = 0; k < 400; k++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_tuse_rs = 2'($urandom_range(0, 3)); id_tuse_rt = 2'($urandom_range(0, 3));
      ex_wa = 5'($urandom_range(0, 3)); ex_tnew = 2'($urandom_range(0, 2));
      mem_wa = 5'($urandom_range(0, 3)); mem_tnew = 2'($urandom_range(0, 1));
      id_is_md = 1'($urandom_range(0, 1));
      ex_md_start = ($urandom_range(0, 9) == 0);
      ex_md_is_div = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 63) == 0);
      tick("rand", 0, 1'b0);
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
